fill_memory_responder: RTL
==========================

// Module: fill_memory_responder
// PURPOSE
//  Memory-side responder for the cache fill protocol. Accepts one word
//  request per cycle from a cache fill FSM (read or write) and returns read
//  data with a fixed pipelined latency.
//  Sits between the I/D cache miss paths and backing storage. Replaces the
//  ad-hoc delay chain with one shared, latency-accurate model.
// PARAMETERS
//  LATENCY    4   cycles from request acceptance to data_valid; legal 1..8
//  DEPTH_LOG2 12  log2 of the number of 16-bit words in storage
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   reset; synchronous, active-high
//  enable      in   1   request strobe, one request per asserted cycle
//  wr          in   1   1 = write request, 0 = read request (qualified by enable)
//  addr        in   16  byte address; addr[0] ignored
//  data_in     in   16  write data
//  data_out    out  16  read data, valid only when data_valid=1
//  data_valid  out  1   one-cycle pulse per returned read word
//  data_addr   out  16  byte address of the returned word (addr[0] forced 0)
//  err         out  1   out-of-range flag (FILL_MEM_RANGE_CHK_EN only; else tied 0)
// BEHAVIOUR
//  - Reset: data_valid=0, data_out=16'h0000, data_addr=16'h0000, err=0.
//    All in-flight pipeline entries are flushed. Storage contents are NOT cleared.
//  - Always ready; there is no backpressure. A read accepted at edge t asserts
//    data_valid in cycle t+LATENCY. Back-to-back reads produce back-to-back pulses.
//  - Word index = addr[DEPTH_LOG2:1]. Read data is sampled at acceptance. A
//    later write to the same word does not alter an in-flight read.
//  - Write: storage is updated at the accepting edge. No response and no
//    data_valid are produced. A read to that word accepted the next cycle
//    returns the new value.
//  - enable=0 inserts a bubble. The bubble appears as data_valid=0 in the
//    matching output cycle.
//  - Pipeline: LATENCY-entry shift of {valid, addr, data, err}; entries
//    advance every cycle unconditionally.
//  - Reset mid-burst: outstanding reads are dropped. A fill FSM must reissue.
//  - data_out and data_addr hold their last values when data_valid=0.
// CONFIGURATION
//  FILL_MEM_RANGE_CHK_EN defined:
//    - A request with addr[15:DEPTH_LOG2+1] != 0 is an out-of-range access.
//    - Out-of-range write: no storage update.
//    - Out-of-range read: returns data_out=16'h0000 with err=1 alongside data_valid.
//  FILL_MEM_RANGE_CHK_EN undefined:
//    - Upper address bits are ignored, so addresses wrap modulo the depth.
//    - err is tied to 0.
// STRUCTURE
//  - Package fill_mem_pkg holds:
//      WORD_W=16, ADDR_W=16, BLOCK_WORDS=8, DEFAULT_LATENCY=4
//      typedef fill_req_t {wr, addr, data}
//      typedef fill_rsp_t {valid, addr, data, err}
//  - Sub-module fill_mem_delay_line: parameterised LATENCY-stage register of
//    fill_rsp_t with synchronous flush.
//    The top level holds the storage array and request decode.
// TESTING
//  1. Reset, then idle 10 cycles -> data_valid=0 and data_out=0 throughout.
//  2. Write 16'hBEEF to 0x0010, then read 0x0010 the next cycle
//     -> data_valid exactly 4 cycles later, data_out=BEEF, data_addr=0x0010.
//  3. Block fill: 8 consecutive reads 0x0100..0x010E (preloaded k*0x1111)
//     -> 8 consecutive pulses in the same order, with matching data_addr.
//  4. Read 0x0020 (holds 0x1234), then write 0x5678 there on the next cycle
//     -> returned word is 0x1234.
//  5. Assert rst 2 cycles into a 4-read burst
//     -> no data_valid afterwards; storage is still intact on re-read.
//  6. With FILL_MEM_RANGE_CHK_EN, read 0x4000 (DEPTH_LOG2=12)
//     -> data_valid=1, err=1, data=0.
//     Without the macro -> returns word 0x0000's content, err=0.

Source files
------------

// File: rtl/fill_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fill_mem_pkg
// Description : Shared widths, defaults and request/response types for the
//               cache fill memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package fill_mem_pkg;

  localparam int WORD_W          = 16;
  localparam int ADDR_W          = 16;
  localparam int BLOCK_WORDS     = 8;
  localparam int DEFAULT_LATENCY = 4;

  // One request from a cache fill FSM.
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } fill_req_t;

  // One entry travelling down the response pipeline.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
    logic              err;
  } fill_rsp_t;

endpackage
`default_nettype wire

// File: rtl/fill_mem_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : fill_mem_delay_line
// Description : LATENCY-stage shift register of fill_rsp_t. Every stage
//               advances each cycle; flush clears all stages synchronously.
// Ports       : clk     - clock, rising edge
//               flush   - synchronous clear of all stages
//               rsp_in  - entry captured into stage 0
//               rsp_out - entry leaving the last stage
// Revision    : 1.0 - initial release
// ============================================================================
module fill_mem_delay_line
  import fill_mem_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic      clk,
  input  logic      flush,
  input  fill_rsp_t rsp_in,
  output fill_rsp_t rsp_out
);

  fill_rsp_t stage_q [LATENCY];
  fill_rsp_t stage_d [LATENCY];

  always_comb begin
    for (int i = 0; i < LATENCY; i++) begin
      stage_d[i] = '0;
    end
    if (!flush) begin
      stage_d[0] = rsp_in;
      for (int i = 1; i < LATENCY; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LATENCY; i++) begin
      stage_q[i] <= stage_d[i];
    end
  end

  assign rsp_out = stage_q[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/fill_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : fill_memory_responder
// Description : Memory-side responder for the cache fill protocol. Accepts
//               one read or write per cycle, no backpressure, and returns
//               read data exactly LATENCY cycles after acceptance.
// Ports       : clk, rst (sync, active-high)
//               enable, wr, addr, data_in           - request
//               data_out, data_valid, data_addr, err - response
// Config      : FILL_MEM_RANGE_CHK_EN - flag accesses above the storage depth
//               (err=1, zero data, writes dropped). Undefined: addresses wrap
//               modulo the depth and err is tied 0.
// Revision    : 1.0 - initial release
// ============================================================================
module fill_memory_responder
  import fill_mem_pkg::*;
#(
  parameter int LATENCY    = DEFAULT_LATENCY,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] data_in,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  output logic [ADDR_W-1:0] data_addr,
  output logic              err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Storage is intentionally never reset.
  logic [WORD_W-1:0] mem_q [DEPTH];

  fill_req_t             req;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  out_of_range;
  logic                  wr_en;
  fill_rsp_t             rsp_in;
  fill_rsp_t             rsp_out;

  logic [WORD_W-1:0] hold_data_q, hold_data_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;

  // Request decode: byte address is word-aligned up front.
  always_comb begin
    req.wr   = wr;
    req.addr = {addr[ADDR_W-1:1], 1'b0};
    req.data = data_in;
  end

  assign word_idx = req.addr[DEPTH_LOG2:1];

`ifdef FILL_MEM_RANGE_CHK_EN
  assign out_of_range = (req.addr >> (DEPTH_LOG2 + 1)) != '0;
  logic unused_bits;
  assign unused_bits = ^{addr[0], req.addr[0]};
`else
  assign out_of_range = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{addr[0], req.addr[0], req.addr[ADDR_W-1:DEPTH_LOG2+1], rsp_out.err};
`endif

  // Writes land on the accepting edge; nothing is written while in reset.
  assign wr_en = enable & req.wr & ~out_of_range & ~rst;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[word_idx] <= req.data;
    end
  end

  // Read data is captured at acceptance, so a following write to the same
  // word cannot disturb the in-flight response.
  always_comb begin
    rsp_in.valid = enable & ~req.wr;
    rsp_in.addr  = req.addr;
    rsp_in.data  = out_of_range ? '0 : mem_q[word_idx];
    rsp_in.err   = out_of_range;
  end

  fill_mem_delay_line #(
    .LATENCY (LATENCY)
  ) u_delay_line (
    .clk     (clk),
    .flush   (rst),
    .rsp_in  (rsp_in),
    .rsp_out (rsp_out)
  );

  // Hold registers keep the last returned word visible between pulses.
  always_comb begin
    hold_data_d = hold_data_q;
    hold_addr_d = hold_addr_q;
    if (rst) begin
      hold_data_d = '0;
      hold_addr_d = '0;
    end else if (rsp_out.valid) begin
      hold_data_d = rsp_out.data;
      hold_addr_d = rsp_out.addr;
    end
  end

  always_ff @(posedge clk) begin
    hold_data_q <= hold_data_d;
    hold_addr_q <= hold_addr_d;
  end

  assign data_valid = rsp_out.valid;
  assign data_out   = rsp_out.valid ? rsp_out.data : hold_data_q;
  assign data_addr  = rsp_out.valid ? rsp_out.addr : hold_addr_q;

`ifdef FILL_MEM_RANGE_CHK_EN
  assign err = rsp_out.valid & rsp_out.err;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire
